// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: width default,
// funct3 encodings, FSM states and the operand-signedness decode.
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Returns {a_signed, b_signed} for the given operation.
  function automatic logic [1:0] op_signed(input logic [2:0] f3);
    logic [1:0] s;
    s = 2'b00;
    case (f3)
      F3_MULH, F3_DIV, F3_REM: s = 2'b11;
      F3_MULHSU:               s = 2'b10;
      default:                 s = 2'b00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Launch/result bundle between the core execute stage and the muldiv unit.
interface muldiv_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, funct3, op_a, op_b, input busy, done, result);
  modport slave  (input start, funct3, op_a, op_b, output busy, done, result);
endinterface

// File: rtl/muldiv_iter.sv
// Shared radix-2 iteration datapath: shift-add multiply or restoring divide on magnitudes.
// Latency: one iteration per step; next-state values are exposed combinationally from registers.
// Backpressure: none; the owner drives load/step and must hold step low when idle.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic            mode,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] hi_nxt,
  output logic [XLEN-1:0] lo_nxt
);

  // hi: product high word / partial remainder; lo: multiplier / quotient.
  logic [XLEN-1:0] hi, lo, opb;
  logic [XLEN:0]   sum, shifted, diff;

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    shifted = {hi, lo[XLEN-1]};
    diff    = shifted - {1'b0, opb};
    hi_nxt  = sum[XLEN:1];
    lo_nxt  = {sum[0], lo[XLEN-1:1]};
    if (mode) begin
      if (!diff[XLEN]) begin
        hi_nxt = diff[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_nxt = shifted[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi  <= '0;
      lo  <= '0;
      opb <= '0;
    end else if (load) begin
      hi  <= '0;
      lo  <= a;
      opb <= b;
    end else if (step) begin
      hi  <= hi_nxt;
      lo  <= lo_nxt;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide execute unit with sign handling and special-case override.
// Latency: fixed XLEN iterations from accepted start to done, plus one DONE cycle (34-cycle throughput).
// Backpressure: none; start is only sampled in IDLE and the core stalls while busy.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  localparam int              CW      = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [2:0]      f3;
  logic            neg_a, neg_b, div_zero, ovf;
  logic [XLEN-1:0] a_raw;
  logic [XLEN-1:0] result_q;
  logic            load, step;

  logic [1:0]      sgn;
  logic            a_neg_in, b_neg_in, ovf_in;
  logic [XLEN-1:0] a_mag, b_mag;

  assign sgn      = op_signed(bus.funct3);
  assign a_neg_in = sgn[1] & bus.op_a[XLEN-1];
  assign b_neg_in = sgn[0] & bus.op_b[XLEN-1];
  assign a_mag    = a_neg_in ? -bus.op_a : bus.op_a;
  assign b_mag    = b_neg_in ? -bus.op_b : bus.op_b;
  assign ovf_in   = ((bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM)) &&
                    (bus.op_a == MIN_INT) && (&bus.op_b);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  logic [XLEN-1:0] hi_nxt, lo_nxt;

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .step   (step),
    .mode   (f3[2]),
    .a      (a_mag),
    .b      (b_mag),
    .hi_nxt (hi_nxt),
    .lo_nxt (lo_nxt)
  );

  // Result is taken from the final iteration's next values, so it lands on the same edge.
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quot_s, rem_s, res_sel;

  always_comb begin
    prod    = {hi_nxt, lo_nxt};
    prod_s  = (neg_a ^ neg_b) ? -prod : prod;
    quot_s  = (neg_a ^ neg_b) ? -lo_nxt : lo_nxt;
    rem_s   = neg_a ? -hi_nxt : hi_nxt;
    res_sel = '0;
    case (f3)
      F3_MUL:                      res_sel = prod_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: res_sel = prod_s[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:             res_sel = div_zero ? '1 : (ovf ? MIN_INT : quot_s);
      default:                     res_sel = div_zero ? a_raw : (ovf ? '0 : rem_s);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      f3       <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
      a_raw    <= '0;
      result_q <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        cnt      <= '0;
        f3       <= bus.funct3;
        neg_a    <= a_neg_in;
        neg_b    <= b_neg_in;
        div_zero <= (bus.op_b == '0);
        ovf      <= ovf_in;
        a_raw    <= bus.op_a;
      end else if (step) begin
        cnt <= cnt + 1'b1;
      end
      if (step && (cnt == LAST)) result_q <= res_sel;
    end
  end

  assign bus.busy   = (state == RUN);
  assign bus.done   = (state == DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  muldiv_if #(.XLEN(32)) bus();

  muldiv_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Launch one operation at the next edge, then follow it to the DONE cycle.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output int bc, output logic dn, output logic [31:0] res);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.op_a   = a;
    bus.op_b   = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
    bc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.busy) bc++;
      else break;
    end
    dn  = bus.done;
    res = bus.result;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    bus.start  = 1'b1;
    bus.funct3 = F3_MUL;
    bus.op_a   = 32'd3;
    bus.op_b   = 32'd4;
    #1;
    n_cmp++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", bus.result); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_start_held: busy %b want 0", bus.busy); end
    reset     = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic test_mul();
    int bc; logic dn; logic [31:0] res;
    do_op(F3_MUL, 32'd7, 32'hFFFFFFFD, bc, dn, res);
    n_cmp++; if (bc !== 32) begin n_fail++; $display("FAIL mul_busy_cycles: got %0d want 32", bc); end
    n_cmp++; if (dn !== 1'b1) begin n_fail++; $display("FAIL mul_done: got %b want 1", dn); end
    n_cmp++; if (res !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mul_result: got %h want ffffffeb", res); end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL mul_done_pulse: got %b want 0", bus.done); end
    n_cmp++; if (bus.result !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mul_result_held: got %h want ffffffeb", bus.result); end
  endtask

  task automatic run_table(input string tag, input logic [2:0] f [4], input logic [31:0] a [4],
                           input logic [31:0] b [4], input logic [31:0] e [4], input int n);
    int bc; logic dn; logic [31:0] res;
    for (int i = 0; i < n; i++) begin
      do_op(f[i], a[i], b[i], bc, dn, res);
      n_cmp++; if (res !== e[i]) begin n_fail++; $display("FAIL %s_%0d result: got %h want %h", tag, i, res, e[i]); end
      n_cmp++; if (bc !== 32 || dn !== 1'b1) begin n_fail++; $display("FAIL %s_%0d timing: busy %0d done %b want 32/1", tag, i, bc, dn); end
    end
  endtask

  task automatic test_mulh();
    logic [2:0]  f [4] = '{F3_MULH, F3_MULHU, F3_MULHSU, F3_MUL};
    logic [31:0] a [4] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
    logic [31:0] b [4] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
    logic [31:0] e [4] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0};
    run_table("mulh", f, a, b, e, 3);
  endtask

  task automatic test_div();
    logic [2:0]  f [4] = '{F3_DIV, F3_REM, F3_DIVU, F3_REMU};
    logic [31:0] a [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
    logic [31:0] b [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] e [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
    run_table("div", f, a, b, e, 4);
  endtask

  task automatic test_special();
    logic [2:0]  f [4] = '{F3_DIVU, F3_REM, F3_DIV, F3_REM};
    logic [31:0] a [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] b [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] e [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};
    run_table("special", f, a, b, e, 4);
  endtask

  task automatic test_mid_start();
    int bc;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = F3_DIVU; bus.op_a = 32'd100; bus.op_b = 32'd7;
    @(posedge clk);
    #1 bus.start = 1'b0;
    bc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.busy) bc++;
      else break;
      if (i == 4) begin
        bus.start = 1'b1; bus.funct3 = F3_MUL; bus.op_a = 32'd9; bus.op_b = 32'd9;
      end
      if (i == 5) bus.start = 1'b0;
    end
    n_cmp++; if (bc !== 32) begin n_fail++; $display("FAIL mid_start_cycles: got %0d want 32", bc); end
    n_cmp++; if (bus.done !== 1'b1 || bus.result !== 32'd14) begin
      n_fail++; $display("FAIL mid_start_result: done %b result %h want 1/0000000e", bus.done, bus.result);
    end
  endtask

  task automatic test_hold_start();
    int bc;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = F3_REMU; bus.op_a = 32'd100; bus.op_b = 32'd7;
    bc = 0;
    @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.busy) bc++;
      else break;
      if (i == 8) bus.op_a = 32'd1000;
    end
    n_cmp++; if (bc !== 32 || bus.result !== 32'd2) begin
      n_fail++; $display("FAIL hold_first: busy %0d result %h want 32/00000002", bc, bus.result);
    end
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL hold_no_relaunch_e33: busy %b done %b want 0/0", bus.busy, bus.done);
    end
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL hold_relaunch_e34: busy %b want 1", bus.busy); end
    bus.start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    n_cmp++; if (bus.done !== 1'b1 || bus.result !== 32'd6) begin
      n_fail++; $display("FAIL hold_second: done %b result %h want 1/00000006", bus.done, bus.result);
    end
  endtask

  task automatic test_reset_mid();
    int bc; logic dn; logic [31:0] res;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = F3_MULHU; bus.op_a = 32'hFFFFFFFF; bus.op_b = 32'hFFFFFFFF;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_mid_result: got %h want 0", bus.result); end
    @(negedge clk);
    reset = 1'b0;
    do_op(F3_DIV, 32'hFFFFFFF9, 32'd2, bc, dn, res);
    n_cmp++; if (bc !== 32 || dn !== 1'b1 || res !== 32'hFFFFFFFD) begin
      n_fail++; $display("FAIL reset_mid_relaunch: busy %0d done %b result %h want 32/1/fffffffd", bc, dn, res);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_mid_start();
    test_hold_start();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
